// File: rtl/write_back_unit.sv
// Write-back stage: result select, registered register-file write,
// and a DEPTH-entry output-port FIFO drained by valid/ready.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_valid          instruction present at this stage
//   sel, src_data     source select and packed source buses
//   rd_addr           destination register
//   reg_write         instruction writes the register file
//   out_write         instruction writes the output port
//   stall             FIFO full and an OUT instruction is waiting
//   fwd_data          selected result, combinational
//   wb_en/addr/data   registered register-file write
//   port_valid/data   FIFO head, port_ready pops it
//   fifo_count        entries held
//   sel_err           sticky invalid-select flag
module write_back_unit #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [SEL_W-1:0]           sel,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       reg_write,
  input  logic                       out_write,
  output logic                       stall,
  output logic [WIDTH-1:0]           fwd_data,
  output logic                       wb_en,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [WIDTH-1:0]           wb_data,
  output logic                       port_valid,
  output logic [WIDTH-1:0]           port_data,
  input  logic                       port_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       sel_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             full;
  logic             accept;
  logic             good;
  logic             push;
  logic             pop;

  assign sel_ok = int'(sel) < NUM_SRC;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(sel) == k) begin
        sel_data = src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational outputs are forced to zero while reset is held.
  assign fwd_data = rst ? '0 : sel_data;

  assign full  = (fifo_count == FULL);
  // port_ready is left out so a full FIFO stalls even while popping;
  // this keeps stall free of any combinational path from the consumer.
  assign stall = ~rst & in_valid & out_write & full;

  assign accept = in_valid & ~stall;
  assign good   = accept & sel_ok;
  assign push   = good & out_write;

  assign port_valid = (fifo_count != '0);
  assign pop        = port_valid & port_ready;
  assign port_data  = port_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en   <= good & reg_write;
      wb_addr <= rd_addr;
      wb_data <= fwd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: port_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fwd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept & ~sel_ok) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_write_back_unit.sv
// Directed self-checking bench for write_back_unit.
// Default parameters: WIDTH=16, NUM_SRC=3, DEPTH=4.
module tb_write_back_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  sel;
  logic [47:0] src_data;
  logic [2:0]  rd_addr;
  logic        reg_write;
  logic        out_write;
  logic        stall;
  logic [15:0] fwd_data;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        port_valid;
  logic [15:0] port_data;
  logic        port_ready;
  logic [2:0]  fifo_count;
  logic        sel_err;

  int total;
  int bad;
  logic [15:0] q[$];
  logic [15:0] exp_head;

  write_back_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sel        (sel),
    .src_data   (src_data),
    .rd_addr    (rd_addr),
    .reg_write  (reg_write),
    .out_write  (out_write),
    .stall      (stall),
    .fwd_data   (fwd_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .port_valid (port_valid),
    .port_data  (port_data),
    .port_ready (port_ready),
    .fifo_count (fifo_count),
    .sel_err    (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // src_data = {mem, alu, imm}
  task automatic src(input logic [15:0] imm,
                     input logic [15:0] alu,
                     input logic [15:0] mdat);
    src_data = {mdat, alu, imm};
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    sel = 2'd0;
    src(16'h0, 16'h0, 16'h0);
    rd_addr = 3'd0;
    reg_write = 1'b0;
    out_write = 1'b0;
    port_ready = 1'b0;
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_pv", port_valid, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_sel_err", sel_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Register write through the ALU source
    in_valid = 1'b1;
    sel = 2'd1;
    src(16'h0042, 16'h1234, 16'h5555);
    rd_addr = 3'd5;
    reg_write = 1'b1;
    #1;
    check("fwd_alu", fwd_data, 16'h1234);
    check("stall_idle", stall, 0);
    sel = 2'd0;
    #1;
    check("fwd_imm", fwd_data, 16'h0042);
    sel = 2'd2;
    #1;
    check("fwd_mem", fwd_data, 16'h5555);
    sel = 2'd1;
    tick;
    check("wb_en", wb_en, 1);
    check("wb_addr", wb_addr, 5);
    check("wb_data", wb_data, 16'h1234);
    in_valid = 1'b0;
    tick;
    check("wb_en_pulse", wb_en, 0);

    // Back-to-back pushes into an empty FIFO
    reg_write = 1'b0;
    out_write = 1'b1;
    in_valid = 1'b1;
    sel = 2'd0;
    src(16'h0011, 16'h0, 16'h0);
    #1;
    check("empty_pv", port_valid, 0);
    tick;
    check("first_pv", port_valid, 1);
    check("first_pd", port_data, 16'h0011);
    check("first_cnt", fifo_count, 1);
    src(16'h0022, 16'h0, 16'h0);
    tick;
    check("second_cnt", fifo_count, 2);
    check("head_hold", port_data, 16'h0011);
    in_valid = 1'b0;
    port_ready = 1'b1;
    tick;
    check("drain1_pd", port_data, 16'h0022);
    tick;
    check("drain2_cnt", fifo_count, 0);
    check("drain2_pv", port_valid, 0);
    port_ready = 1'b0;

    // Fill to DEPTH, stall, then drain in order
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src(16'h000A + 16'(i), 16'h0, 16'h0);
      tick;
    end
    check("full_cnt", fifo_count, 4);
    src(16'h000E, 16'h0, 16'h0);
    #1;
    check("full_stall", stall, 1);
    tick;
    check("stalled_cnt", fifo_count, 4);
    port_ready = 1'b1;
    #1;
    check("stall_pop", stall, 1);
    check("head_A", port_data, 16'h000A);
    tick;
    check("pop_A_cnt", fifo_count, 3);
    check("unstall", stall, 0);
    check("head_B", port_data, 16'h000B);
    tick;
    check("pushE_cnt", fifo_count, 3);
    in_valid = 1'b0;
    check("head_C", port_data, 16'h000C);
    tick;
    check("head_D", port_data, 16'h000D);
    tick;
    check("head_E", port_data, 16'h000E);
    tick;
    check("empty_after", fifo_count, 0);
    port_ready = 1'b0;

    // Simultaneous push/pop at count 2 with pointer wrap
    q.delete();
    in_valid = 1'b1;
    src(16'h0101, 16'h0, 16'h0);
    q.push_back(16'h0101);
    tick;
    src(16'h0202, 16'h0, 16'h0);
    q.push_back(16'h0202);
    tick;
    check("pp_start_cnt", fifo_count, 2);
    port_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src((i == 0) ? 16'hBEEF : 16'hB000 + 16'(i), 16'h0, 16'h0);
      q.push_back(src_data[15:0]);
      exp_head = q.pop_front();
      check($sformatf("pp_head%0d", i), port_data, exp_head);
      tick;
      check($sformatf("pp_cnt%0d", i), fifo_count, 2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_head = q.pop_front();
      check($sformatf("pp_tail%0d", i), port_data, exp_head);
      tick;
    end
    check("pp_empty", fifo_count, 0);
    port_ready = 1'b0;

    // Invalid select
    in_valid = 1'b1;
    sel = 2'd3;
    reg_write = 1'b1;
    out_write = 1'b1;
    src(16'h1111, 16'h2222, 16'h3333);
    #1;
    check("bad_fwd", fwd_data, 0);
    tick;
    check("bad_wb_en", wb_en, 0);
    check("bad_cnt", fifo_count, 0);
    check("bad_err", sel_err, 1);
    in_valid = 1'b0;
    sel = 2'd0;
    tick;
    tick;
    check("err_sticky", sel_err, 1);

    // Reset mid-stream with three entries queued
    in_valid = 1'b1;
    reg_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src(16'h0C00 + 16'(i), 16'h0, 16'h0);
      reg_write = (i == 2);
      tick;
    end
    check("pre_rst_cnt", fifo_count, 3);
    check("pre_rst_wb", wb_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cnt", fifo_count, 0);
    check("mid_rst_pv", port_valid, 0);
    check("mid_rst_pd", port_data, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_wb_data", wb_data, 0);
    check("mid_rst_fwd", fwd_data, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_err", sel_err, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick;
    check("post_rst_cnt", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
